mux_cfg_ctrl: RTL
=================

# mux_cfg_ctrl

Wishbone-slave configuration controller that drives the 4-bit `configuration` bus shared by every `v_line` instance in the 2x2 array. Software writes a new array configuration; the block accepts it and blanks all pad output enables for a guard window around the switch (`blank_o`, ANDed into every `*_oe_selected` at top level). The active configuration then changes in a single cycle, so no pad is ever driven by two macros, or by a half-switched mux, during reconfiguration.

## Interface
- `BASE_ADDR`, 32'h3000_0000, register block base; decode uses bits [31:4].
- `RESET_CFG`, 4'd0, `configuration_o` value after reset.
- `GUARD_RST`, 8'd4, reset value of the GUARD register.

- `wb_clk_i`  in  1  sole clock
- `wb_rst_ni`  in  1  asynchronous, active-low reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe/cycle/write
- `wbs_sel_i`  in  4  byte selects; only `sel[0]` is honoured
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address / write data
- `wbs_ack_o`  out  1  single-cycle acknowledge
- `wbs_dat_o`  out  32  read data, valid while ack is high, else 0
- `configuration_o`  out  4  active configuration to all `v_line` blocks
- `blank_o`  out  1  force all pad OE low
- `busy_o`  out  1  switch sequence in progress

## Operation
- Registers at offset `adr[3:2]`:
  - 0 CONFIG: write `[3:0]` = requested config. Read `[3:0]` active, `[7:4]` pending, `[8]` pending valid.
  - 1 STATUS: read `[1:0]` state, `[2]` busy, `[3]` err. Writing 1 to `[3]` clears err.
  - 2 GUARD: `[7:0]` guard cycle count, R/W.
  - 3: reads 0, writes ignored.
- Decode: `adr[31:4] != BASE_ADDR[31:4]` -> no ack. A write with `sel[0]=0` is acked but ignored.
- CONFIG write with value > 3 is rejected: pending is unchanged, err is set (sticky).
- A valid CONFIG write loads pending and sets pending-valid. The last write wins, including writes made while busy.
- FSM states: IDLE(0), PRE(1), SWITCH(2), POST(3).
  - IDLE, pending valid, pending == active: clear pending-valid, stay in IDLE.
  - IDLE, pending valid, pending != active: load counter from GUARD, clear pending-valid, capture the target, go to PRE.
  - PRE: counter == 0 -> SWITCH; else decrement.
  - SWITCH: one cycle; `configuration_o` <= target on exit; load counter from GUARD; go to POST.
  - POST: counter == 0 -> IDLE; else decrement.
- `blank_o` = 1 and `busy_o` = 1 in PRE, SWITCH and POST.
- A GUARD write takes effect at the next counter load. Writing GUARD mid-phase does not alter the running count.

## Timing
- All outputs are registered.
- Reset values: `configuration_o`=RESET_CFG, `blank_o`=0, `busy_o`=0, `wbs_ack_o`=0, `wbs_dat_o`=0, state IDLE, GUARD=GUARD_RST, err=0, pending-valid=0.
- Ack: high for exactly one cycle after the edge sampling `stb&cyc` with ack low. There are never back-to-back acks, so minimum access time is 2 cycles. Register writes take effect on that same edge.
- Write accepted at edge E0 -> PRE entered at edge E1:
  - `blank_o` rises after E1.
  - `configuration_o` changes after edge E1+GUARD+1.
  - `blank_o` is high for exactly 2·GUARD+1 cycles.
- GUARD=0: blank lasts 1 cycle (SWITCH only), and the config changes at the end of that cycle.
- Pending written during POST: the next sequence starts on the first IDLE cycle. There is one IDLE cycle with `blank_o`=0 between sequences.
- Asynchronous reset mid-sequence: immediate return to reset values, and the pending request is lost.
- An in-flight Wishbone access interrupted by reset is not acked.

## Structure
- Package `mux_cfg_pkg`:
  - state enum (IDLE/PRE/SWITCH/POST, 2 bits)
  - register offsets
  - `CFG_MAX`=3
  - STATUS bit indices
- Sub-module `mux_cfg_seq`: the FSM, guard counter and active/target registers.
- The top level holds the Wishbone decode, the pending/err/GUARD registers and read muxing.

## Test plan
- Reset: hold `wb_rst_ni`=0 mid-clock -> `configuration_o`=0, `blank_o`=0, GUARD reads 4, STATUS reads 0.
- Write CONFIG=2 with GUARD=4 -> `blank_o` high for 9 cycles; `configuration_o` becomes 2 after the 5th blank cycle; `busy_o` matches `blank_o`.
- Write CONFIG=0 while active=0 -> no blank, pending-valid clears, and CONFIG reads 0x000.
- Write CONFIG=5 -> ack, STATUS.err=1, config unchanged; write STATUS=0x8 -> err=0.
- GUARD=0, write 1 then write 3 during POST of a GUARD=2 sequence -> two sequences separated by exactly one IDLE cycle; final `configuration_o`=3.
- Assert reset during PRE -> `blank_o`=0 immediately; config=RESET_CFG; a later write to address BASE_ADDR+0x10 gets no ack.

Source files
------------

// File: rtl/mux_cfg_pkg.sv
// Shared types and constants for the pad-array configuration controller.
package mux_cfg_pkg;

  localparam int unsigned CFG_W     = 4;
  localparam int unsigned GUARD_W   = 8;
  localparam int unsigned WB_W      = 32;
  localparam int unsigned REG_SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRE    = 2'd1,
    ST_SWITCH = 2'd2,
    ST_POST   = 2'd3
  } state_e;

  localparam logic [REG_SEL_W-1:0] REG_CONFIG = REG_SEL_W'(0);
  localparam logic [REG_SEL_W-1:0] REG_STATUS = REG_SEL_W'(1);
  localparam logic [REG_SEL_W-1:0] REG_GUARD  = REG_SEL_W'(2);
  localparam logic [REG_SEL_W-1:0] REG_RSVD   = REG_SEL_W'(3);

  localparam logic [CFG_W-1:0] CFG_MAX = CFG_W'(3);

  localparam int unsigned ST_BUSY_BIT = 2;
  localparam int unsigned ST_ERR_BIT  = 3;

  // CONFIG register read layout
  typedef struct packed {
    logic [22:0]      rsvd;
    logic             pend_vld;
    logic [CFG_W-1:0] pend;
    logic [CFG_W-1:0] active;
  } cfg_rd_t;

  // STATUS register read layout
  typedef struct packed {
    logic [27:0] rsvd;
    logic        err;
    logic        busy;
    logic [1:0]  state;
  } status_rd_t;

  function automatic logic cfg_ok(input logic [CFG_W-1:0] cfg);
    return cfg <= CFG_MAX;
  endfunction

endpackage

// File: rtl/mux_cfg_seq.sv
// Switch sequencer: guard-window FSM, guard counter and active/target configuration.
module mux_cfg_seq
  import mux_cfg_pkg::*;
#(
  parameter logic [CFG_W-1:0] RESET_CFG = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pend_vld,
  input  logic [CFG_W-1:0]   pend,
  input  logic [GUARD_W-1:0] guard,
  output logic               take_c,
  output logic [1:0]         state,
  output logic [CFG_W-1:0]   active,
  output logic               blank,
  output logic               busy
);

  state_e             st, st_d;
  logic [GUARD_W-1:0] cnt, cnt_d;
  logic [CFG_W-1:0]   tgt, tgt_d;
  logic [CFG_W-1:0]   act_d;

  assign state = st;

  // Each guard phase lasts exactly `guard` cycles; a zero guard skips PRE/POST entirely.
  always_comb begin
    st_d   = st;
    cnt_d  = cnt;
    tgt_d  = tgt;
    act_d  = active;
    take_c = 1'b0;
    case (st)
      ST_IDLE: begin
        if (pend_vld) begin
          take_c = 1'b1;
          if (pend != active) begin
            tgt_d = pend;
            if (guard == '0) begin
              st_d = ST_SWITCH;
            end else begin
              st_d  = ST_PRE;
              cnt_d = guard - GUARD_W'(1);
            end
          end
        end
      end
      ST_PRE: begin
        if (cnt == '0) st_d = ST_SWITCH;
        else           cnt_d = cnt - GUARD_W'(1);
      end
      ST_SWITCH: begin
        act_d = tgt;
        if (guard == '0) begin
          st_d = ST_IDLE;
        end else begin
          st_d  = ST_POST;
          cnt_d = guard - GUARD_W'(1);
        end
      end
      ST_POST: begin
        if (cnt == '0) st_d = ST_IDLE;
        else           cnt_d = cnt - GUARD_W'(1);
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Blank/busy are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      tgt    <= RESET_CFG;
      active <= RESET_CFG;
      blank  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      st     <= st_d;
      cnt    <= cnt_d;
      tgt    <= tgt_d;
      active <= act_d;
      blank  <= (st_d != ST_IDLE);
      busy   <= (st_d != ST_IDLE);
    end
  end

endmodule

// File: rtl/mux_cfg_ctrl.sv
// Wishbone-slave controller for the shared v_line configuration bus with
// pad-OE blanking around every configuration switch.
module mux_cfg_ctrl
  import mux_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [3:0]  RESET_CFG = 4'd0,
  parameter logic [7:0]  GUARD_RST = 8'd4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  configuration_o,
  output logic        blank_o,
  output logic        busy_o
);

  logic                 hit, acc, wr;
  logic                 wr_cfg, wr_status, wr_guard;
  logic [REG_SEL_W-1:0] reg_sel;
  logic [CFG_W-1:0]     new_cfg;
  logic                 new_ok;
  logic [WB_W-1:0]      rd_data;

  logic [CFG_W-1:0]     pend;
  logic                 pend_vld;
  logic                 err;
  logic [GUARD_W-1:0]   guard;
  logic                 take_c;
  logic [1:0]           seq_state;
  logic                 seq_busy;

  cfg_rd_t              cfg_rd;
  status_rd_t           status_rd;

  logic                 unused_ok;
  assign unused_ok = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:8], seq_busy};

  // Decode: one access per two cycles because ack must be low to accept.
  assign hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign acc       = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & hit;
  assign wr        = acc & wbs_we_i & wbs_sel_i[0];
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr_cfg    = wr && (reg_sel == REG_CONFIG);
  assign wr_status = wr && (reg_sel == REG_STATUS);
  assign wr_guard  = wr && (reg_sel == REG_GUARD);
  assign new_cfg   = wbs_dat_i[CFG_W-1:0];
  assign new_ok    = cfg_ok(new_cfg);

  always_comb begin
    cfg_rd    = '{rsvd: '0, pend_vld: pend_vld, pend: pend, active: configuration_o};
    status_rd = '{rsvd: '0, err: err, busy: busy_o, state: seq_state};
    rd_data   = '0;
    case (reg_sel)
      REG_CONFIG: rd_data = cfg_rd;
      REG_STATUS: rd_data = status_rd;
      REG_GUARD:  rd_data = {{(WB_W-GUARD_W){1'b0}}, guard};
      REG_RSVD:   rd_data = '0;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rd_data : '0;
    end
  end

  // A fresh write beats the sequencer consuming the previous request.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pend     <= '0;
      pend_vld <= 1'b0;
      err      <= 1'b0;
      guard    <= GUARD_RST;
    end else begin
      if (wr_cfg && new_ok) begin
        pend     <= new_cfg;
        pend_vld <= 1'b1;
      end else if (take_c) begin
        pend_vld <= 1'b0;
      end
      if (wr_cfg && !new_ok) begin
        err <= 1'b1;
      end else if (wr_status && wbs_dat_i[ST_ERR_BIT]) begin
        err <= 1'b0;
      end
      if (wr_guard) begin
        guard <= wbs_dat_i[GUARD_W-1:0];
      end
    end
  end

  mux_cfg_seq #(
    .RESET_CFG (RESET_CFG)
  ) u_seq (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .pend_vld (pend_vld),
    .pend     (pend),
    .guard    (guard),
    .take_c   (take_c),
    .state    (seq_state),
    .active   (configuration_o),
    .blank    (blank_o),
    .busy     (seq_busy)
  );

  assign busy_o = seq_busy;

endmodule
